packet_unpacker: RTL
====================

# packet_unpacker

Downstream stage of the packet reassembly buffer. Takes each completed packet entry (`packet_types::packet_element_t`) offered at the head of the completed-index queue and streams its flits, in order, over a valid/ready flit interface to the local consumer (router-local port or host bridge). Once the last flit has been accepted, it pulses `transfered_packet_completed` so the buffer frees the entry and pops its queue.

## Interface
- `MAX_FLITS`, 8: flit capacity of one packet entry. Must equal the depth of `packet_element_t.buffer`.
- `IDX_W`, `$clog2(MAX_FLITS+1)`: width of the internal flit index and length registers.

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- `nocclk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `transfered_packet`  in  `packet_types::packet_element_t`  packet at the queue head. Stable while `transfered_packet_valid`=1.
- `transfered_packet_valid`  in  1  a completed packet is offered.
- `transfered_packet_completed`  out  1  one-cycle pulse; frees and pops the offered packet.
- `out_flit`  out  `types::flit_t`  current flit.
- `out_flit_valid`  out  1  `out_flit` is valid.
- `out_flit_ready`  in  1  consumer accepts.
- `out_flit_last`  out  1  current flit is the packet's final flit.
- `out_packet_id`  out  `types::packet_id_t`  id of the packet being streamed.
- `seq_error`  out  1  one-cycle pulse on a sequence error. Tied to 0 without `PACKET_UNPACKER_CHECK_EN`.

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - If `transfered_packet_valid`=1: latch `len` = `tail_index` and `out_packet_id` = `packet_id`; clear `idx`.
  - Go to STREAM if 1 ≤ `len` ≤ `MAX_FLITS`; otherwise go directly to DONE (empty or corrupt entry, no flits emitted).
- STREAM:
  - `out_flit_valid`=1.
  - `out_flit` = `transfered_packet.buffer[idx]`, driven combinationally from the stable input.
  - `out_flit_last` = (`idx` == `len`−1).
  - On handshake (valid & ready), increment `idx`. On handshake with `out_flit_last`=1, go to DONE.
- DONE: `transfered_packet_completed`=1 for exactly this cycle, then go to IDLE.
- `transfered_packet_completed` is asserted only while `transfered_packet_valid`=1. If valid has dropped by DONE, no pulse is generated and the FSM returns to IDLE.
- `idx` and `len` are IDX_W bits wide and are never compared beyond `len`. No wrap-around is possible.
- Once `out_flit_valid` rises, it stays high until the handshake. `out_flit` holds its value while stalled.

## Timing
- Reset values: FSM=IDLE, `idx`=0, `len`=0, `out_packet_id`=0, `out_flit_valid`=0, `out_flit_last`=0, `transfered_packet_completed`=0, `seq_error`=0. `out_flit` is don't-care while valid is low and is driven to 0.
- Latency: valid seen in IDLE at cycle T → first flit valid at T+1.
- An N-flit packet with ready held at 1 occupies cycles T+1..T+N in STREAM. DONE pulses at T+N+1, and IDLE can accept the next packet at T+N+2.
- Back-to-back overhead: 2 cycles per packet.
- Single-flit packets (system flits) go IDLE → STREAM (with `out_flit_last`=1) → DONE.
- Reset asserted mid-STREAM: return to IDLE immediately, with no completed pulse. The buffer keeps the entry, and it is re-streamed from flit 0 after reset.

## Configuration
- Macro: `PACKET_UNPACKER_CHECK_EN`.
- When defined, each flit is checked in STREAM before it is presented:
  - `buffer[idx].header.flit_id.flit_num` must equal `idx`.
  - `buffer[idx].header.flit_id.packet_id` must equal the latched `out_packet_id`.
- On a mismatch:
  - `out_flit_valid` stays 0 for that flit.
  - `seq_error` pulses for 1 cycle.
  - The FSM goes to DONE, so the entry is freed and the packet is truncated.
- When undefined: no checks are made, and flits stream blindly.

## Test plan
- 3-flit packet (`tail_index`=3, `packet_id`=5), ready=1 → flits 0,1,2 on cycles T+1..T+3; `last` only on flit 2; completed pulse at T+4; `out_packet_id`=5.
- Same packet with ready low on the cycle flit 1 is presented, for 4 cycles → flit 1 held stable and valid throughout; completed pulse delayed by 4 cycles.
- `tail_index`=1 (system flit) → one flit with `last`=1; completed 2 cycles after valid.
- `tail_index`=0 → no `out_flit_valid`; completed pulse at T+1.
- Reset pulse during flit 1 of a 4-flit packet → outputs at reset values; after release, the stream restarts at flit 0 and all 4 flits plus the completed pulse are seen.
- With `PACKET_UNPACKER_CHECK_EN`, `buffer[1].flit_num`=3 → flit 0 is emitted, then `seq_error`=1, then completed; without the macro, all flits stream unchanged.

Source files
------------

// File: rtl/packet_unpacker.sv
// rtl/packet_unpacker.sv - streams a completed packet entry as valid/ready flits
// Optional flit sequence checking is enabled with the PACKET_UNPACKER_CHECK_EN macro.
package types;
  typedef logic [3:0] packet_id_t;

  typedef struct packed {
    packet_id_t packet_id;
    logic [2:0] flit_num;
  } flit_id_t;

  typedef struct packed {
    flit_id_t   flit_id;
    logic [3:0] vc_dest;
  } header_t;

  typedef struct packed {
    header_t     header;
    logic [31:0] payload;
  } flit_t;
endpackage

package packet_types;
  localparam int MAX_FLITS_PER_PACKET = 8;

  typedef struct packed {
    types::packet_id_t                              packet_id;
    logic [3:0]                                     tail_index;
    types::flit_t [MAX_FLITS_PER_PACKET-1:0]        buffer;
  } packet_element_t;
endpackage

module packet_unpacker #(
  parameter int MAX_FLITS = 8,
  parameter int IDX_W     = $clog2(MAX_FLITS + 1)
) (
  input  logic                          nocclk,
  input  logic                          rst,
  input  packet_types::packet_element_t transfered_packet,
  input  logic                          transfered_packet_valid,
  output logic                          transfered_packet_completed,
  output types::flit_t                  out_flit,
  output logic                          out_flit_valid,
  input  logic                          out_flit_ready,
  output logic                          out_flit_last,
  output types::packet_id_t             out_packet_id,
  output logic                          seq_error
);

  localparam int SEL_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_len;
  types::packet_id_t r_packet_id;
  logic [IDX_W-1:0]  w_tail;
  logic              w_len_ok;
  types::flit_t      w_cur;
  logic              w_last;
  logic              w_seq_err;

  assign w_tail        = IDX_W'(transfered_packet.tail_index);
  assign w_len_ok      = (w_tail != '0) && (w_tail <= IDX_W'(MAX_FLITS));
  assign w_cur         = transfered_packet.buffer[r_idx[SEL_W-1:0]];
  assign w_last        = (r_idx == r_len - IDX_W'(1));
  assign out_packet_id = r_packet_id;

`ifdef PACKET_UNPACKER_CHECK_EN
  // A flit whose header disagrees with its slot or packet is never presented.
  assign w_seq_err = (r_state == S_STREAM) &&
                     ((IDX_W'(w_cur.header.flit_id.flit_num) != r_idx) ||
                      (w_cur.header.flit_id.packet_id != r_packet_id));
`else
  assign w_seq_err = 1'b0;
`endif

  always_comb begin
    w_next                      = r_state;
    out_flit                    = '0;
    out_flit_valid              = 1'b0;
    out_flit_last               = 1'b0;
    transfered_packet_completed = 1'b0;
    seq_error                   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (transfered_packet_valid) begin
          w_next = w_len_ok ? S_STREAM : S_DONE;
        end
      end
      S_STREAM: begin
        if (w_seq_err) begin
          seq_error = 1'b1;
          w_next    = S_DONE;
        end else begin
          out_flit_valid = 1'b1;
          out_flit       = w_cur;
          out_flit_last  = w_last;
          if (out_flit_ready && w_last) begin
            w_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        // No pulse if the buffer withdrew the entry; freeing it twice would corrupt the queue.
        transfered_packet_completed = transfered_packet_valid;
        w_next                      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_packet_id <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (transfered_packet_valid) begin
            r_len       <= w_tail;
            r_packet_id <= transfered_packet.packet_id;
            r_idx       <= '0;
          end
        end
        S_STREAM: begin
          if (out_flit_valid && out_flit_ready) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
